vga_centroid_ctrl: RTL

Sequences the per-frame threshold accumulator and turns its raw sums into a published target centroid. The block arms and clears the accumulator, snapshots its running count and sums at frame end, and computes rounded averages with a serial restoring divider. The accumulator keeps collecting the next frame while the divider runs. Results go to the tracking/motor logic over a valid/ready handshake.

---
 rtl/vga_centroid_ctrl_if.sv | 22 ++
 rtl/vga_centroid_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vga_centroid_ctrl_if.sv
// Result channel from the centroid controller to the tracking/motor logic.
// valid/ready handshake carrying the found flag, rounded centroid and pixel count.
interface vga_centroid_ctrl_if #(
  parameter int unsigned CNT_W = 17
);
  logic             res_valid;
  logic             res_ready;
  logic             res_found;
  logic [8:0]       res_x;
  logic [7:0]       res_y;
  logic [CNT_W-1:0] res_cnt;

  modport master (
    output res_valid, res_found, res_x, res_y, res_cnt,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_found, res_x, res_y, res_cnt,
    output res_ready
  );
endinterface

// File: rtl/vga_centroid_ctrl.sv
// Frame accumulator sequencer plus serial restoring divider producing a rounded,
// saturated target centroid published over a valid/ready channel.
module vga_centroid_ctrl #(
  parameter int unsigned VGA_WIDTH  = 320,
  parameter int unsigned VGA_HEIGHT = 240,
  parameter int unsigned SUM_W      = 25,
  parameter int unsigned CNT_W      = 17,
  parameter int unsigned MIN_CNT    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic                 frame_end_i,
  input  logic [SUM_W-1:0]     sum_x_i,
  input  logic [SUM_W-1:0]     sum_y_i,
  input  logic [CNT_W-1:0]     cnt_i,
  output logic                 accu_en_o,
  output logic                 accu_clr_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  vga_centroid_ctrl_if.master  res_if
);

  typedef enum logic [1:0] {OFF, ARM, RUN} ctrl_e;
  typedef enum logic [1:0] {D_IDLE, D_X, D_Y, D_OUT} div_e;

  localparam int unsigned       CYC_W    = $clog2(SUM_W);
  localparam logic [CYC_W-1:0]  LAST_CYC = CYC_W'(SUM_W - 1);

  ctrl_e              ctrl_q, ctrl_d;
  div_e               div_q, div_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W:0]     rem_q, rem_d;
  logic [SUM_W-1:0]   quo_q, quo_d;
  logic [SUM_W:0]     ny_q, ny_d;
  logic [SUM_W-1:0]   qx_q, qx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               clr_q, clr_d;
  logic               ovr_q, ovr_d;
  logic               valid_q, valid_d;
  logic               found_q, found_d;
  logic [8:0]         x_q, x_d;
  logic [7:0]         y_q, y_d;
  logic [CNT_W-1:0]   rcnt_q, rcnt_d;

  logic [CNT_W-1:0]   half_cnt;
  logic [SUM_W:0]     nx, ny;
  logic [CNT_W:0]     trial, step_rem;
  logic               ge;
  logic [SUM_W-1:0]   step_quo;
  logic               fe_run, accept;

  // Rounding bias folded into a SUM_W+1-bit dividend; its MSB seeds the remainder
  // since the divisor is at least MIN_CNT and that quotient bit is always zero.
  assign half_cnt = {1'b0, cnt_i[CNT_W-1:1]};
  assign nx       = {1'b0, sum_x_i} + {{(SUM_W+1-CNT_W){1'b0}}, half_cnt};
  assign ny       = {1'b0, sum_y_i} + {{(SUM_W+1-CNT_W){1'b0}}, half_cnt};

  assign trial    = {rem_q[CNT_W-1:0], quo_q[SUM_W-1]};
  assign ge       = trial >= {1'b0, cnt_q};
  assign step_rem = ge ? (trial - {1'b0, cnt_q}) : trial;
  assign step_quo = {quo_q[SUM_W-2:0], ge};

  assign fe_run = frame_end_i && (ctrl_q == RUN);
  assign accept = fe_run && (div_q == D_IDLE) && (!valid_q || res_if.res_ready);

  always_comb begin
    ctrl_d  = ctrl_q;
    div_d   = div_q;
    cyc_d   = cyc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    ny_d    = ny_q;
    qx_d    = qx_q;
    cnt_d   = cnt_q;
    clr_d   = fe_run;
    ovr_d   = fe_run && !accept;
    valid_d = valid_q;
    found_d = found_q;
    x_d     = x_q;
    y_d     = y_q;
    rcnt_d  = rcnt_q;

    unique case (ctrl_q)
      OFF:     if (enable_i) ctrl_d = ARM;
      ARM:     ctrl_d = RUN;
      RUN:     if (!enable_i) ctrl_d = OFF;
      default: ctrl_d = OFF;
    endcase

    if (valid_q && res_if.res_ready) valid_d = 1'b0;

    unique case (div_q)
      D_IDLE: begin
        if (accept) begin
          cnt_d = cnt_i;
          rem_d = {{CNT_W{1'b0}}, nx[SUM_W]};
          quo_d = nx[SUM_W-1:0];
          ny_d  = ny;
          cyc_d = '0;
          div_d = (cnt_i < CNT_W'(MIN_CNT)) ? D_OUT : D_X;
        end
      end
      D_X: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == LAST_CYC) begin
          qx_d  = step_quo;
          rem_d = {{CNT_W{1'b0}}, ny_q[SUM_W]};
          quo_d = ny_q[SUM_W-1:0];
          cyc_d = '0;
          div_d = D_Y;
        end
      end
      D_Y: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == LAST_CYC) div_d = D_OUT;
      end
      D_OUT: begin
        valid_d = 1'b1;
        rcnt_d  = cnt_q;
        if (cnt_q < CNT_W'(MIN_CNT)) begin
          found_d = 1'b0;
          x_d     = '1;
          y_d     = '1;
        end else begin
          found_d = 1'b1;
          x_d     = (qx_q  > SUM_W'(VGA_WIDTH - 1))  ? 9'(VGA_WIDTH - 1)  : qx_q[8:0];
          y_d     = (quo_q > SUM_W'(VGA_HEIGHT - 1)) ? 8'(VGA_HEIGHT - 1) : quo_q[7:0];
        end
        div_d = D_IDLE;
      end
      default: div_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= OFF;
      div_q   <= D_IDLE;
      cyc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      ny_q    <= '0;
      qx_q    <= '0;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
      ovr_q   <= 1'b0;
      valid_q <= 1'b0;
      found_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      rcnt_q  <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      div_q   <= div_d;
      cyc_q   <= cyc_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      ny_q    <= ny_d;
      qx_q    <= qx_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      ovr_q   <= ovr_d;
      valid_q <= valid_d;
      found_q <= found_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign accu_en_o  = (ctrl_q == RUN);
  assign accu_clr_o = (ctrl_q == ARM) || clr_q;
  assign busy_o     = (div_q == D_X) || (div_q == D_Y);
  assign overrun_o  = ovr_q;

  assign res_if.res_valid = valid_q;
  assign res_if.res_found = found_q;
  assign res_if.res_x     = x_q;
  assign res_if.res_y     = y_q;
  assign res_if.res_cnt   = rcnt_q;

endmodule
